// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch stage.
// Provides XLEN, the fetch FSM state enum and default reset/NOP constants.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry {pcplus4, instruction} buffer used while stalled.
// Ports: clk, rst (async high), load, clear, in_pcplus4, in_instr
//        -> pcplus4, instruction, full.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] in_pcplus4,
    input  logic [XLEN-1:0] in_instr,
    output logic [XLEN-1:0] pcplus4,
    output logic [XLEN-1:0] instruction,
    output logic            full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcplus4     <= '0;
            instruction <= '0;
            full        <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            pcplus4     <= in_pcplus4;
            instruction <= in_instr;
            full        <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, requests instructions over imem req/ack and
// drives the registered {pcplus4, instruction, valid} IF/ID bundle.
// Ports: clk, rst (async high), stall, redirect, redirect_pc,
//        imem_req/imem_addr/imem_ack/imem_rdata, pcplus4, instruction, valid.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pcplus4,
    output logic [XLEN-1:0] instruction,
    output logic            valid
);

    localparam logic [XLEN-1:0] ALIGN = ~32'h3;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc, pc_nx;
    logic [XLEN-1:0] req_addr, req_addr_nx;
    logic [XLEN-1:0] pcplus4_nx, instr_nx;
    logic            valid_nx;
    logic [XLEN-1:0] pc_inc, target;
    logic            buf_load, buf_clear, buf_full;
    logic [XLEN-1:0] buf_pcplus4, buf_instr;

    assign pc_inc = pc + 32'd4;
    assign target = redirect_pc & ALIGN;

    // Request is combinationally gated by rst so memory sees it drop at once.
    assign imem_req  = !rst && (state == FETCH || state == DISCARD);
    assign imem_addr = req_addr;

    fetch_hold_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .clear       (buf_clear),
        .in_pcplus4  (pc_inc),
        .in_instr    (imem_rdata),
        .pcplus4     (buf_pcplus4),
        .instruction (buf_instr),
        .full        (buf_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC & ALIGN;
            req_addr    <= RESET_PC & ALIGN;
            pcplus4     <= '0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            req_addr    <= req_addr_nx;
            pcplus4     <= pcplus4_nx;
            instruction <= instr_nx;
            valid       <= valid_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_addr_nx = req_addr;
        pcplus4_nx  = pcplus4;
        instr_nx    = instruction;
        valid_nx    = valid;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        if (redirect) begin
            pc_nx      = target;
            pcplus4_nx = '0;
            instr_nx   = NOP_INSTR;
            valid_nx   = 1'b0;
            buf_clear  = 1'b1;
            // An unanswered request must still be drained before refetching.
            if (!imem_ack && state != HOLD) begin
                state_nx = DISCARD;
            end else begin
                state_nx    = FETCH;
                req_addr_nx = target;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        pc_nx       = pc_inc;
                        req_addr_nx = pc_inc;
                        if (stall) begin
                            buf_load = 1'b1;
                            state_nx = HOLD;
                        end else begin
                            pcplus4_nx = pc_inc;
                            instr_nx   = imem_rdata;
                            valid_nx   = 1'b1;
                        end
                    end else if (!stall) begin
                        instr_nx = NOP_INSTR;
                        valid_nx = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pcplus4_nx = buf_pcplus4;
                        instr_nx   = buf_instr;
                        valid_nx   = buf_full;
                        buf_clear  = 1'b1;
                        state_nx   = FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_nx    = FETCH;
                        req_addr_nx = pc;
                    end
                end
                default: state_nx = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage, default and wrap-around
// RESET_PC instances, checking the IF/ID outputs and imem request side.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        req;
    logic [31:0] addr, pcp4, instr;
    logic        vld;

    logic        rst1 = 1'b1;
    logic        ack1 = 1'b0;
    logic [31:0] rdata1 = '0;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = '0;
    logic        req1;
    logic [31:0] addr1, pcp4_1, instr1;
    logic        vld1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_stage u0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(req), .imem_addr(addr),
        .imem_ack(ack), .imem_rdata(rdata), .pcplus4(pcp4),
        .instruction(instr), .valid(vld)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk(clk), .rst(rst1), .stall(zero1), .redirect(zero1),
        .redirect_pc(zero32), .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack1), .imem_rdata(rdata1), .pcplus4(pcp4_1),
        .instruction(instr1), .valid(vld1)
    );

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] p4,
                           input logic [31:0] ins, input logic v);
        chk({tag, ".pcplus4"}, pcp4, p4);
        chk({tag, ".instr"}, instr, ins);
        chk({tag, ".valid"}, {31'd0, vld}, {31'd0, v});
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst.req", {31'd0, req}, 32'd0);
        chk_out("rst", 32'd0, NOP, 1'b0);

        // zero-wait sequential fetch
        rst = 1'b0;
        #1;
        chk("rel.req", {31'd0, req}, 32'd1);
        chk("rel.addr", addr, 32'h0);
        ack = 1'b1;
        rdata = dat(32'h0);
        tick();
        chk_out("zw0", 32'h4, dat(32'h0), 1'b1);
        chk("zw0.addr", addr, 32'h4);
        rdata = dat(32'h4);
        tick();
        chk_out("zw1", 32'h8, dat(32'h4), 1'b1);
        chk("zw1.addr", addr, 32'h8);
        rdata = dat(32'h8);
        tick();
        chk_out("zw2", 32'hC, dat(32'h8), 1'b1);
        chk("zw2.addr", addr, 32'hC);

        // two wait cycles for 0xC
        ack = 1'b0;
        tick();
        chk_out("w1", 32'hC, NOP, 1'b0);
        chk("w1.addr", addr, 32'hC);
        tick();
        chk_out("w2", 32'hC, NOP, 1'b0);
        chk("w2.addr", addr, 32'hC);
        ack = 1'b1;
        rdata = dat(32'hC);
        tick();
        chk_out("w3", 32'h10, dat(32'hC), 1'b1);
        chk("w3.addr", addr, 32'h10);

        // stall on the ack for 0x10
        stall = 1'b1;
        rdata = dat(32'h10);
        tick();
        ack = 1'b0;
        chk_out("st0", 32'h10, dat(32'hC), 1'b1);
        chk("st0.req", {31'd0, req}, 32'd0);
        tick();
        chk_out("st1", 32'h10, dat(32'hC), 1'b1);
        chk("st1.req", {31'd0, req}, 32'd0);
        stall = 1'b0;
        tick();
        chk_out("st2", 32'h14, dat(32'h10), 1'b1);
        chk("st2.req", {31'd0, req}, 32'd1);
        chk("st2.addr", addr, 32'h14);

        // advance to 0x20, then redirect to 0x103 while 0x20 is waiting
        ack = 1'b1;
        for (int a = 32'h14; a <= 32'h1C; a += 4) begin
            rdata = dat(32'(a));
            tick();
        end
        chk_out("adv", 32'h20, dat(32'h1C), 1'b1);
        chk("adv.addr", addr, 32'h20);
        ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        chk_out("rd0", 32'h0, NOP, 1'b0);
        chk("rd0.addr", addr, 32'h20);
        chk("rd0.req", {31'd0, req}, 32'd1);
        tick();
        chk_out("rd1", 32'h0, NOP, 1'b0);
        chk("rd1.addr", addr, 32'h20);
        ack = 1'b1;
        rdata = dat(32'h20);
        tick();
        chk_out("rd2", 32'h0, NOP, 1'b0);
        chk("rd2.addr", addr, 32'h100);
        rdata = dat(32'h100);
        tick();
        chk_out("rd3", 32'h104, dat(32'h100), 1'b1);
        chk("rd3.addr", addr, 32'h104);

        // redirect + stall while HOLD is full
        stall = 1'b1;
        rdata = dat(32'h104);
        tick();
        chk_out("hr0", 32'h104, dat(32'h100), 1'b1);
        chk("hr0.req", {31'd0, req}, 32'd0);
        ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk_out("hr1", 32'h0, NOP, 1'b0);
        chk("hr1.addr", addr, 32'h200);
        chk("hr1.req", {31'd0, req}, 32'd1);
        stall = 1'b0;
        ack = 1'b1;
        rdata = dat(32'h200);
        tick();
        chk_out("hr2", 32'h204, dat(32'h200), 1'b1);
        ack = 1'b0;
        tick();
        chk_out("hr3", 32'h204, NOP, 1'b0);
        chk("hr3.addr", addr, 32'h204);

        // reset in the middle of a wait
        rst = 1'b1;
        #1;
        chk_out("mr", 32'h0, NOP, 1'b0);
        chk("mr.req", {31'd0, req}, 32'd0);
        chk("mr.addr", addr, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr.rel", {31'd0, req}, 32'd1);

        // wrap-around instance
        chk("wr.rstreq", {31'd0, req1}, 32'd0);
        rst1 = 1'b0;
        #1;
        chk("wr.addr0", addr1, 32'hFFFF_FFFC);
        ack1 = 1'b1;
        rdata1 = dat(32'hFFFF_FFFC);
        tick();
        chk("wr.p4_0", pcp4_1, 32'h0);
        chk("wr.ins0", instr1, dat(32'hFFFF_FFFC));
        chk("wr.v0", {31'd0, vld1}, 32'd1);
        chk("wr.addr1", addr1, 32'h0);
        rdata1 = dat(32'h0);
        tick();
        chk("wr.p4_1", pcp4_1, 32'h4);
        chk("wr.ins1", instr1, dat(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
